// File: rtl/decoder_3to8_if.sv
// Select/enable inputs and one-hot line outputs of the registered 3-to-8 decoder.
// master drives the select side; slave is the decoder itself.
interface decoder_3to8_if;
    logic a;
    logic b;
    logic c;
    logic en;
    logic d0;
    logic d1;
    logic d2;
    logic d3;
    logic d4;
    logic d5;
    logic d6;
    logic d7;
    logic valid;

    modport master (
        output a, b, c, en,
        input  d0, d1, d2, d3, d4, d5, d6, d7, valid
    );

    modport slave (
        input  a, b, c, en,
        output d0, d1, d2, d3, d4, d5, d6, d7, valid
    );
endinterface

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 line decoder: {a,b,c} selects one of eight lines on the clk edge when en=1.
// The line flops hold the output polarity directly, so d0..d7 come straight from registers.
module decoder_3to8 #(
    parameter bit ACTIVE_LOW  = 1'b0,
    parameter bit RESET_VALID = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    decoder_3to8_if.slave  bus
);
    localparam int unsigned LINES = 8;
    localparam int unsigned SEL_W = 3;

    logic [SEL_W-1:0] sel_c;
    logic [LINES-1:0] lines_c;
    logic [LINES-1:0] d_next_c;
    logic [LINES-1:0] d_q;
    logic             valid_q;

    // One-hot decode of the select, then polarity applied before the flops.
    always_comb begin
        sel_c    = {bus.a, bus.b, bus.c};
        lines_c  = '0;
        if (bus.en) begin
            lines_c = LINES'(1) << sel_c;
        end
        d_next_c = ACTIVE_LOW ? ~lines_c : lines_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q     <= {LINES{ACTIVE_LOW}};
            valid_q <= RESET_VALID;
        end else begin
            d_q     <= d_next_c;
            valid_q <= bus.en;
        end
    end

    assign bus.d0    = d_q[0];
    assign bus.d1    = d_q[1];
    assign bus.d2    = d_q[2];
    assign bus.d3    = d_q[3];
    assign bus.d4    = d_q[4];
    assign bus.d5    = d_q[5];
    assign bus.d6    = d_q[6];
    assign bus.d7    = d_q[7];
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_decoder_3to8.sv
// Bench for decoder_3to8: an active-high and an active-low instance driven in lockstep,
// compared against an arithmetic model of the select rules.
module tb_decoder_3to8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decoder_3to8_if bus_h ();
    decoder_3to8_if bus_l ();

    decoder_3to8 #(.ACTIVE_LOW(1'b0), .RESET_VALID(1'b0)) dut_h (
        .clk (clk),
        .rst (rst),
        .bus (bus_h.slave)
    );

    decoder_3to8 #(.ACTIVE_LOW(1'b1), .RESET_VALID(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    // Reference: line i is on exactly when enabled and i equals 4a+2b+c.
    function automatic logic [7:0] model_lines(input bit a, input bit b, input bit c, input bit en);
        logic [7:0] r;
        int sel;
        sel = (a ? 4 : 0) + (b ? 2 : 0) + (c ? 1 : 0);
        for (int i = 0; i < 8; i++) r[i] = en && (i == sel);
        return r;
    endfunction

    function automatic logic [7:0] obs_h();
        return {bus_h.d7, bus_h.d6, bus_h.d5, bus_h.d4, bus_h.d3, bus_h.d2, bus_h.d1, bus_h.d0};
    endfunction

    function automatic logic [7:0] obs_l();
        return {bus_l.d7, bus_l.d6, bus_l.d5, bus_l.d4, bus_l.d3, bus_l.d2, bus_l.d1, bus_l.d0};
    endfunction

    task automatic apply(input bit a, input bit b, input bit c, input bit en);
        bus_h.a = a; bus_h.b = b; bus_h.c = c; bus_h.en = en;
        bus_l.a = a; bus_l.b = b; bus_l.c = c; bus_l.en = en;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_release();
        #2 rst = 1'b1;
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (obs_h() !== 8'h00 || bus_h.valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_h[%0d]: got d=%b valid=%b, expected d=00000000 valid=0", k, obs_h(), bus_h.valid);
            end
            checks++;
            if (obs_l() !== 8'hFF || bus_l.valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_l[%0d]: got d=%b valid=%b, expected d=11111111 valid=0", k, obs_l(), bus_l.valid);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs_h() !== 8'h00 || bus_h.valid !== 1'b0) begin
            errors++;
            $display("FAIL release_pre_edge: got d=%b valid=%b, expected d=00000000 valid=0", obs_h(), bus_h.valid);
        end
        cycle();
        checks++;
        if (obs_h() !== 8'b0001_0000 || bus_h.valid !== 1'b1) begin
            errors++;
            $display("FAIL release_first_edge_h: got d=%b valid=%b, expected d=00010000 valid=1", obs_h(), bus_h.valid);
        end
        checks++;
        if (obs_l() !== 8'b1110_1111 || bus_l.valid !== 1'b1) begin
            errors++;
            $display("FAIL release_first_edge_l: got d=%b valid=%b, expected d=11101111 valid=1", obs_l(), bus_l.valid);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        for (int s = 0; s < 8; s++) begin
            apply(s[2], s[1], s[0], 1'b1);
            cycle();
            exp = model_lines(s[2], s[1], s[0], 1'b1);
            checks++;
            if (obs_h() !== exp || bus_h.valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep_h sel=%0d: got d=%b valid=%b, expected d=%b valid=1", s, obs_h(), bus_h.valid, exp);
            end
            checks++;
            if (obs_l() !== ~exp || bus_l.valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep_l sel=%0d: got d=%b valid=%b, expected d=%b valid=1", s, obs_l(), bus_l.valid, ~exp);
            end
        end
    endtask

    task automatic test_enable();
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        checks++;
        if (obs_h() !== 8'h00 || bus_h.valid !== 1'b0 || obs_l() !== 8'hFF || bus_l.valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_off: got d_h=%b v_h=%b d_l=%b v_l=%b, expected 00000000 0 11111111 0",
                     obs_h(), bus_h.valid, obs_l(), bus_l.valid);
        end
        apply(1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        checks++;
        if (obs_h() !== 8'b0000_1000 || bus_h.valid !== 1'b1 || obs_l() !== 8'b1111_0111) begin
            errors++;
            $display("FAIL enable_on: got d_h=%b v_h=%b d_l=%b, expected 00001000 1 11110111",
                     obs_h(), bus_h.valid, obs_l());
        end
    endtask

    task automatic test_hold();
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        apply(1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (obs_h() !== 8'b0000_0001) begin
            errors++;
            $display("FAIL hold_mid1: got d=%b, expected d=00000001", obs_h());
        end
        #1 apply(1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (obs_h() !== 8'b0000_0001 || obs_l() !== 8'b1111_1110) begin
            errors++;
            $display("FAIL hold_mid2: got d_h=%b d_l=%b, expected 00000001 11111110", obs_h(), obs_l());
        end
        cycle();
        checks++;
        if (obs_h() !== 8'b0000_0100 || bus_h.valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_after_edge: got d=%b valid=%b, expected d=00000100 valid=1", obs_h(), bus_h.valid);
        end
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        checks++;
        if (obs_h() !== 8'b1000_0000 || bus_h.valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got d=%b valid=%b, expected d=10000000 valid=1", obs_h(), bus_h.valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_h() !== 8'h00 || bus_h.valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_h: got d=%b valid=%b, expected d=00000000 valid=0", obs_h(), bus_h.valid);
        end
        checks++;
        if (obs_l() !== 8'hFF || bus_l.valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_l: got d=%b valid=%b, expected d=11111111 valid=0", obs_l(), bus_l.valid);
        end
        @(negedge clk);
        checks++;
        if (obs_h() !== 8'h00 || bus_h.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_through_edge: got d=%b valid=%b, expected d=00000000 valid=0", obs_h(), bus_h.valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        bit a, b, c, en;
        for (int k = 0; k < 48; k++) begin
            a  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            c  = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 3) != 0);
            apply(a, b, c, en);
            cycle();
            exp = model_lines(a, b, c, en);
            checks++;
            if (obs_h() !== exp || bus_h.valid !== en) begin
                errors++;
                $display("FAIL random_h[%0d] abc=%b%b%b en=%b: got d=%b valid=%b, expected d=%b valid=%b",
                         k, a, b, c, en, obs_h(), bus_h.valid, exp, en);
            end
            checks++;
            if (obs_l() !== ~exp || bus_l.valid !== en) begin
                errors++;
                $display("FAIL random_l[%0d] abc=%b%b%b en=%b: got d=%b valid=%b, expected d=%b valid=%b",
                         k, a, b, c, en, obs_l(), bus_l.valid, ~exp, en);
            end
            checks++;
            if ($countones(obs_h()) != (bus_h.valid ? 1 : 0)) begin
                errors++;
                $display("FAIL onehot[%0d]: got %0d lines with valid=%b, expected %0d",
                         k, $countones(obs_h()), bus_h.valid, (bus_h.valid ? 1 : 0));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        test_reset_release();
        test_sweep();
        test_enable();
        test_hold();
        test_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
